osc_bank: RTL and testbench

Time-multiplexed multi-channel oscillator bank. It is the parametrised successor to the single-channel quarter-sine lookup. It holds one phase accumulator per channel and advances the selected channel by a caller-supplied increment on each accepted request. It generates sine (quarter-wave ROM with mirror/invert), triangle, saw or square at a configurable amplitude width, with a fixed-latency valid/channel-tagged pipeline. It sits between the voice/note controller and the mixer.

---
 rtl/osc_bank_pkg.sv | 36 +++
 rtl/quarter_sine_rom.sv | 30 +++
 rtl/osc_bank.sv | 137 +++++++++++++
 tb/tb_osc_bank.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/osc_bank_pkg.sv
// Shared definitions for the oscillator bank: default widths, waveform
// encodings and elaboration-time helpers.
package osc_bank_pkg;

  localparam int DEF_PHASE_W    = 24;
  localparam int DEF_AMP_W      = 16;
  localparam int DEF_ROM_ADDR_W = 8;
  localparam int DEF_CHANNELS   = 8;

  localparam real PI = 3.14159265358979323846;

  typedef enum logic [1:0] {
    MODE_SINE   = 2'd0,
    MODE_TRI    = 2'd1,
    MODE_SAW    = 2'd2,
    MODE_SQUARE = 2'd3
  } mode_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Quarter-wave table entry, sampled at the centre of each address step.
  function automatic int sine_word(input int idx, input int addr_w, input int data_w);
    real full_scale;
    real angle;
    full_scale = real'((1 << data_w) - 1);
    angle      = (PI / 2.0) * (real'(idx) + 0.5) / real'(1 << addr_w);
    return $rtoi(full_scale * $sin(angle) + 0.5);
  endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// Synchronous-read quarter-wave sine table with a one-cycle registered output.
module quarter_sine_rom
  import osc_bank_pkg::*;
#(
  parameter int ADDR_W = DEF_ROM_ADDR_W,
  parameter int DATA_W = DEF_AMP_W - 1
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] rom_tbl [DEPTH];
  logic [DATA_W-1:0] data_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign rom_tbl[g] = DATA_W'(sine_word(g, ADDR_W, DATA_W));
  end

  // NOTE: a ROM read register needs no reset; its contents are meaningless
  // until a valid flag travelling alongside says otherwise.
  always_ff @(posedge clk) begin
    data_q <= rom_tbl[addr_i];
  end

  assign data_o = data_q;

endmodule

// File: rtl/osc_bank.sv
// Time-multiplexed oscillator bank: per-channel phase accumulators feeding a
// three-stage sine/triangle/saw/square pipeline with channel-tagged output.
module osc_bank
  import osc_bank_pkg::*;
#(
  parameter  int PHASE_W    = DEF_PHASE_W,
  parameter  int AMP_W      = DEF_AMP_W,
  parameter  int ROM_ADDR_W = DEF_ROM_ADDR_W,
  parameter  int CHANNELS   = DEF_CHANNELS,
  localparam int CH_W       = ch_width(CHANNELS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [CH_W-1:0]    in_chan,
  input  logic [PHASE_W-1:0] in_incr,
  input  logic               in_sync,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  output logic [CH_W-1:0]    out_chan,
  output logic [AMP_W-1:0]   out_amp
);

  // Only the top phase bits that feed the ROM address or the waveform
  // shapers are carried down the pipeline.
  localparam int S1_W = max_int(AMP_W + 1, ROM_ADDR_W + 2);
  localparam int S2_W = AMP_W + 1;
  localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(CHANNELS);
  localparam logic [AMP_W-1:0] AMP_MID  = {1'b1, {(AMP_W - 1){1'b0}}};

  logic [PHASE_W-1:0] acc_q [CHANNELS];

  logic               in_range;
  logic [PHASE_W-1:0] phase_d;

  logic               s1_valid_q;
  logic [CH_W-1:0]    s1_chan_q;
  mode_e              s1_mode_q;
  logic [S1_W-1:0]    s1_phase_q;
  logic [ROM_ADDR_W-1:0] rom_addr;

  logic               s2_valid_q;
  logic [CH_W-1:0]    s2_chan_q;
  mode_e              s2_mode_q;
  logic [S2_W-1:0]    s2_phase_q;
  logic [AMP_W-2:0]   rom_data;

  logic [AMP_W-1:0]   tri_t;
  logic [AMP_W-1:0]   amp_d;

  logic               out_valid_q;
  logic [CH_W-1:0]    out_chan_q;
  logic [AMP_W-1:0]   out_amp_q;

  assign in_range = {1'b0, in_chan} < CH_LIMIT;
  assign phase_d  = (in_sync || !in_range) ? '0 : acc_q[in_chan];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
    end else if (in_valid && in_range) begin
      acc_q[in_chan] <= phase_d + in_incr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
    end
    if (in_valid) begin
      s1_chan_q  <= in_chan;
      s1_mode_q  <= mode_e'(in_mode);
      s1_phase_q <= phase_d[PHASE_W-1 -: S1_W];
    end
  end

  // Odd quadrants run the table backwards.
  assign rom_addr = s1_phase_q[S1_W-2] ? ~s1_phase_q[S1_W-3 -: ROM_ADDR_W]
                                       :  s1_phase_q[S1_W-3 -: ROM_ADDR_W];

  quarter_sine_rom #(
    .ADDR_W (ROM_ADDR_W),
    .DATA_W (AMP_W - 1)
  ) u_rom (
    .clk    (clk),
    .addr_i (rom_addr),
    .data_o (rom_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q;
    end
    s2_chan_q  <= s1_chan_q;
    s2_mode_q  <= s1_mode_q;
    s2_phase_q <= s1_phase_q[S1_W-1 -: S2_W];
  end

  assign tri_t = s2_phase_q[AMP_W-1:0];

  always_comb begin
    amp_d = AMP_MID;
    case (s2_mode_q)
      MODE_SINE:   amp_d = s2_phase_q[AMP_W] ? AMP_MID - AMP_W'(rom_data)
                                             : AMP_MID + AMP_W'(rom_data);
      MODE_TRI:    amp_d = s2_phase_q[AMP_W] ? ~tri_t : tri_t;
      MODE_SAW:    amp_d = s2_phase_q[AMP_W -: AMP_W];
      MODE_SQUARE: amp_d = s2_phase_q[AMP_W] ? '0 : '1;
      default:     amp_d = AMP_MID;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_amp_q   <= AMP_MID;
    end else begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_chan_q <= s2_chan_q;
        out_amp_q  <= amp_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign out_amp   = out_amp_q;

endmodule

// File: tb/tb_osc_bank.sv
// Self-checking bench for osc_bank: directed waveform cases plus randomized
// traffic compared against an arithmetic reference model.
module tb_osc_bank;

  localparam int PHASE_W    = 12;
  localparam int AMP_W      = 8;
  localparam int ROM_ADDR_W = 8;
  localparam int CHANNELS   = 4;
  localparam int CH_W       = 2;
  localparam real PI_R      = 3.14159265358979323846;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic [CH_W-1:0]    in_chan = '0;
  logic [PHASE_W-1:0] in_incr = '0;
  logic               in_sync = 1'b0;
  logic [1:0]         in_mode = '0;
  logic               out_valid;
  logic [CH_W-1:0]    out_chan;
  logic [AMP_W-1:0]   out_amp;

  osc_bank #(
    .PHASE_W    (PHASE_W),
    .AMP_W      (AMP_W),
    .ROM_ADDR_W (ROM_ADDR_W),
    .CHANNELS   (CHANNELS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_chan   (in_chan),
    .in_incr   (in_incr),
    .in_sync   (in_sync),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_chan  (out_chan),
    .out_amp   (out_amp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int ch;
    int amp;
    int lit;
  } exp_t;

  exp_t pipe[$];
  int   acc [CHANNELS];
  int   last_chan = 0;
  int   last_amp  = 128;
  int   n_checks  = 0;
  int   n_pass    = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Waveform value for a 12-bit phase, derived from the shape definitions.
  function automatic int model_amp(input int p, input int md);
    int quad, idx, r, t;
    case (md)
      0: begin
        quad = p / 1024;
        idx  = (p % 1024) / 4;
        if (quad % 2 == 1) idx = 255 - idx;
        r = $rtoi(127.0 * $sin(PI_R / 2.0 * (real'(idx) + 0.5) / 256.0) + 0.5);
        return (quad >= 2) ? 128 - r : 128 + r;
      end
      1: begin
        t = (p / 8) % 256;
        return (p < 2048) ? t : 255 - t;
      end
      2: return p / 16;
      default: return (p < 2048) ? 255 : 0;
    endcase
  endfunction

  // One clock cycle: check the output due now, then drive and model a request.
  task automatic step(input bit v, input int ch, input int inc, input bit sy,
                      input int md, input bit r, input int lit);
    exp_t e;
    int   p;
    @(negedge clk);
    if (pipe.size() >= 3) begin
      e = pipe.pop_front();
      if (e.v) begin
        last_chan = e.ch;
        last_amp  = e.amp;
      end
      check("out_valid", int'(out_valid), int'(e.v));
      check("out_chan", int'(out_chan), last_chan);
      check("out_amp", int'(out_amp), last_amp);
      if (e.lit >= 0) check("directed_amp", int'(out_amp), e.lit);
    end
    rst      = r;
    in_valid = v;
    in_chan  = CH_W'(ch);
    in_incr  = PHASE_W'(inc);
    in_sync  = sy;
    in_mode  = 2'(md);
    e = '{v: 1'b0, ch: 0, amp: 0, lit: lit};
    if (r) begin
      foreach (pipe[i]) pipe[i].v = 1'b0;
      foreach (acc[i]) acc[i] = 0;
      last_chan = 0;
      last_amp  = 128;
    end else if (v) begin
      p = (sy || ch >= CHANNELS) ? 0 : acc[ch];
      if (ch < CHANNELS) acc[ch] = (p + inc) % 4096;
      e.v   = 1'b1;
      e.ch  = ch;
      e.amp = model_amp(p, md);
    end
    pipe.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 0, 1'b0, -1);
  endtask

  initial begin
    foreach (acc[i]) acc[i] = 0;

    // Reset state: the first outputs checked come from reset cycles.
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b0, 0, 1'b1, 128);
    idle(2);

    // Sine extremes on ch0.
    step(1'b1, 0, 12'h400, 1'b1, 0, 1'b0, 128);
    step(1'b1, 0, 12'h000, 1'b0, 0, 1'b0, 255);
    step(1'b1, 0, 12'h800, 1'b0, 0, 1'b0, 255);
    step(1'b1, 0, 12'h000, 1'b0, 0, 1'b0, 1);
    idle(2);

    // Saw accumulation on ch2.
    step(1'b1, 2, 12'h100, 1'b1, 2, 1'b0, 8'h00);
    step(1'b1, 2, 12'h100, 1'b0, 2, 1'b0, 8'h10);
    step(1'b1, 2, 12'h100, 1'b0, 2, 1'b0, 8'h20);
    step(1'b1, 2, 12'h100, 1'b0, 2, 1'b0, 8'h30);
    idle(1);

    // Triangle and square breakpoints on ch3.
    step(1'b1, 3, 12'h400, 1'b1, 1, 1'b0, 0);
    step(1'b1, 3, 12'h800, 1'b0, 1, 1'b0, 128);
    step(1'b1, 3, 12'hBFF, 1'b0, 1, 1'b0, 127);
    step(1'b1, 3, 12'h001, 1'b0, 3, 1'b0, 255);
    step(1'b1, 3, 12'h000, 1'b0, 3, 1'b0, 0);
    idle(1);

    // Wrap and interleave ch1/ch3, read out as saw.
    step(1'b1, 1, 12'hF00, 1'b1, 2, 1'b0, 8'h00);
    step(1'b1, 3, 12'h080, 1'b1, 2, 1'b0, 8'h00);
    step(1'b1, 1, 12'hF00, 1'b0, 2, 1'b0, 8'hF0);
    step(1'b1, 3, 12'h080, 1'b0, 2, 1'b0, 8'h08);
    step(1'b1, 1, 12'hF00, 1'b0, 2, 1'b0, 8'hE0);
    step(1'b1, 3, 12'h080, 1'b0, 2, 1'b0, 8'h10);
    idle(3);

    // Reset mid-flight: in-flight samples vanish, accumulators restart at 0.
    step(1'b1, 0, 12'h123, 1'b0, 2, 1'b0, -1);
    step(1'b1, 0, 12'h123, 1'b0, 2, 1'b0, -1);
    step(1'b1, 0, 12'h123, 1'b0, 2, 1'b1, 128);
    step(1'b0, 0, 0, 1'b0, 0, 1'b0, 128);
    step(1'b1, 0, 12'h010, 1'b0, 2, 1'b0, 8'h00);
    idle(3);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 3) != 0,
           int'($urandom_range(0, CHANNELS - 1)),
           int'($urandom_range(0, 4095)),
           $urandom_range(0, 15) == 0,
           int'($urandom_range(0, 3)),
           $urandom_range(0, 499) == 0,
           -1);
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
